// File: rtl/krz_gpio_pkg.sv
// krz_gpio_pkg
// Shared definitions for the KRZ GPIO event block:
//   - register word addresses (GPIO_LEVEL .. GPIO_COUNT)
//   - bus handshake FSM state type
//   - width of the optional event counter (built with KRZ_GPIO_EVT_COUNT_EN)
package krz_gpio_pkg;

  localparam int unsigned GPIO_LEVEL   = 0;
  localparam int unsigned GPIO_RISE_EN = 1;
  localparam int unsigned GPIO_FALL_EN = 2;
  localparam int unsigned GPIO_STATUS  = 3;
  localparam int unsigned GPIO_IRQ_EN  = 4;
  localparam int unsigned GPIO_COUNT   = 5;

  localparam int unsigned GPIO_COUNT_W = 16;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/krz_gpio_edge.sv
// krz_gpio_edge
// Per-pin edge detector. Keeps the previous sampled level and produces a
// one-cycle event vector for enabled rising/falling transitions. A primed
// flag suppresses events on the first cycle out of reset so the reset value
// of prev cannot be mistaken for an edge.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   level[N]        debounced pin levels
//   rise_en[N]      per-pin rising-edge enable
//   fall_en[N]      per-pin falling-edge enable
//   prev[N]         level as sampled on the last clock
//   evt[N]          enabled edge seen this cycle (combinational)
module krz_gpio_edge #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] level,
  input  logic [N-1:0] rise_en,
  input  logic [N-1:0] fall_en,
  output logic [N-1:0] prev,
  output logic [N-1:0] evt
);

  logic [N-1:0] prev_q;
  logic [N-1:0] prev_d;
  logic         primed_q;
  logic         primed_d;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  always_comb begin
    prev_d   = level;
    primed_d = 1'b1;
    rise     = level & ~prev_q & rise_en;
    fall     = ~level & prev_q & fall_en;
    evt      = primed_q ? (rise | fall) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
    end
  end

  assign prev = prev_q;

endmodule

// File: rtl/krz_gpio_event.sv
// krz_gpio_event
// GPIO event capture and interrupt block. Detects enabled edges on the
// debounced level vector, latches them into sticky write-1-to-clear status
// bits and drives a registered level interrupt. Registers are accessed via a
// req/ack port: a request in IDLE performs any write on the same edge that
// enters ACK; ACK lasts one cycle and presents read data.
// Optional feature: define KRZ_GPIO_EVT_COUNT_EN to build a saturating
// 16-bit event counter at address 5 (reads 0 otherwise).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   level[N]        debounced pin levels
//   req, we         single-cycle request, write enable qualified by req
//   addr[AW]        register word address
//   wdata[32]       write data (bits at and above N ignored)
//   rdata[32]       read data, valid while ack=1, zero otherwise
//   ack             one-cycle acknowledge per request
//   irq             level interrupt, |(STATUS & IRQ_EN) registered
module krz_gpio_event
  import krz_gpio_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  level,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          ack,
  output logic          irq
);

  // Bus FSM and captured request
  bus_state_e    state_q;
  bus_state_e    state_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic          we_q;
  logic          we_d;

  // Register file
  logic [N-1:0]  rise_en_q;
  logic [N-1:0]  rise_en_d;
  logic [N-1:0]  fall_en_q;
  logic [N-1:0]  fall_en_d;
  logic [N-1:0]  irq_en_q;
  logic [N-1:0]  irq_en_d;
  logic [N-1:0]  status_q;
  logic [N-1:0]  status_d;
  logic          irq_q;
  logic          irq_d;

  logic [N-1:0]  prev;
  logic [N-1:0]  evt;
  logic          wr_acc;
  logic [N-1:0]  clr;
  logic [31:0]   rd_mux;
  logic          unused_wdata;

  // Bits of wdata above N are architecturally ignored.
  assign unused_wdata = ^wdata;

  krz_gpio_edge #(
    .N (N)
  ) u_edge (
    .clk     (clk),
    .rst     (rst),
    .level   (level),
    .rise_en (rise_en_q),
    .fall_en (fall_en_q),
    .prev    (prev),
    .evt     (evt)
  );

  // A write is accepted only when a request arrives in IDLE; it commits on
  // the same edge that moves the FSM into ACK.
  assign wr_acc = (state_q == BUS_IDLE) && req && we;

  // ---------------------------------------------------------------------
  // Bus FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUS_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

  // Bus FSM: next state. A request while in ACK is dropped.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    case (state_q)
      BUS_IDLE: begin
        if (req) begin
          state_d = BUS_ACK;
          addr_d  = addr;
          we_d    = we;
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      default: state_d = BUS_IDLE;
    endcase
  end

  // Bus FSM: outputs. Read data reflects the register contents during the
  // ACK cycle, so a write is visible to the very next read.
  always_comb begin
    ack   = (state_q == BUS_ACK);
    rdata = '0;
    if ((state_q == BUS_ACK) && !we_q) begin
      rdata = rd_mux;
    end
  end

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
`ifdef KRZ_GPIO_EVT_COUNT_EN
  logic [GPIO_COUNT_W-1:0] count_q;
  logic [GPIO_COUNT_W-1:0] count_d;
`endif

  always_comb begin
    rd_mux = '0;
    case (addr_q)
      AW'(GPIO_LEVEL):   rd_mux[N-1:0] = prev;
      AW'(GPIO_RISE_EN): rd_mux[N-1:0] = rise_en_q;
      AW'(GPIO_FALL_EN): rd_mux[N-1:0] = fall_en_q;
      AW'(GPIO_STATUS):  rd_mux[N-1:0] = status_q;
      AW'(GPIO_IRQ_EN):  rd_mux[N-1:0] = irq_en_q;
`ifdef KRZ_GPIO_EVT_COUNT_EN
      AW'(GPIO_COUNT):   rd_mux[GPIO_COUNT_W-1:0] = count_q;
`endif
      default:           rd_mux = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Register file next state
  // ---------------------------------------------------------------------
  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    clr       = '0;
    if (wr_acc) begin
      case (addr)
        AW'(GPIO_RISE_EN): rise_en_d = wdata[N-1:0];
        AW'(GPIO_FALL_EN): fall_en_d = wdata[N-1:0];
        AW'(GPIO_STATUS):  clr       = wdata[N-1:0];
        AW'(GPIO_IRQ_EN):  irq_en_d  = wdata[N-1:0];
        default: ;
      endcase
    end
    // Set takes priority over a simultaneous W1C of the same bit.
    status_d = (status_q & ~clr) | evt;
    irq_d    = |(status_q & irq_en_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_en_q  <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      irq_en_q  <= irq_en_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  // ---------------------------------------------------------------------
  // Optional saturating event counter
  // ---------------------------------------------------------------------
`ifdef KRZ_GPIO_EVT_COUNT_EN
  // A clear via write to address 5 beats a coincident increment.
  always_comb begin
    count_d = count_q;
    if (wr_acc && (addr == AW'(GPIO_COUNT))) begin
      count_d = '0;
    end else if ((|evt) && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`endif

endmodule

// File: tb/tb_krz_gpio_event.sv
// tb_krz_gpio_event
// Directed bench for krz_gpio_event with hand-computed expectations.
// Inputs are driven on the falling clock edge; outputs are sampled there too.
module tb_krz_gpio_event;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 3;

  localparam logic [AW-1:0] A_LEVEL   = 3'd0;
  localparam logic [AW-1:0] A_RISE_EN = 3'd1;
  localparam logic [AW-1:0] A_FALL_EN = 3'd2;
  localparam logic [AW-1:0] A_STATUS  = 3'd3;
  localparam logic [AW-1:0] A_IRQ_EN  = 3'd4;
  localparam logic [AW-1:0] A_COUNT   = 3'd5;
  localparam logic [AW-1:0] A_RSVD6   = 3'd6;
  localparam logic [AW-1:0] A_RSVD7   = 3'd7;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  level;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ack;
  logic          irq;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  krz_gpio_event #(
    .N  (N),
    .AW (AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .level (level),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .irq   (irq)
  );

  // The bench must never issue a request while ack is high.
  always @(posedge clk) begin
    if (!rst && req && ack) $error("bus request issued during ack cycle");
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete bus transaction. Returns rdata and irq as seen in the ACK
  // cycle and finishes on the falling edge after ack has dropped.
  task automatic bus(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic irq_at_ack);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0; wdata = '0;
    check_val("ack_rise", 32'(ack), 32'h1);
    rd         = rdata;
    irq_at_ack = irq;
    @(negedge clk);
    check_val("ack_fall", 32'(ack), 32'h0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        i;
    bus(1'b1, a, d, rd, i);
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        i;
    bus(1'b0, a, '0, rd, i);
    check_val(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic        irq_ack;

    rst = 1'b1; level = 16'hFFFF; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #1;
    check_val("reset_ack",   32'(ack), 32'h0);
    check_val("reset_irq",   32'(irq), 32'h0);
    check_val("reset_rdata", rdata,    32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Steady high levels out of reset must not create events.
    wr(A_RISE_EN, 32'h0000_FFFF);
    wr(A_IRQ_EN,  32'h0000_FFFF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("prime_irq", 32'(irq), 32'h0);
    end
    rd_chk("prime_status", A_STATUS, 32'h0);

    // Rising edge on pin 0 only.
    wr(A_RISE_EN, 32'h0000_0001);
    wr(A_IRQ_EN,  32'h0000_0001);
    rd_chk("rise_en_rb", A_RISE_EN, 32'h1);
    @(negedge clk); level = 16'hFFFE;
    repeat (3) @(negedge clk);
    rd_chk("fall_ignored", A_STATUS, 32'h0);
    check_val("fall_irq", 32'(irq), 32'h0);
    level = 16'hFFFF;
    @(negedge clk);
    check_val("rise_irq_lag", 32'(irq), 32'h0);
    @(negedge clk);
    check_val("rise_irq", 32'(irq), 32'h1);
    rd_chk("rise_status", A_STATUS, 32'h1);
    level = 16'hFFFE;
    repeat (3) @(negedge clk);
    rd_chk("fall_no_set", A_STATUS, 32'h1);
    rd_chk("level_rb", A_LEVEL, 32'h0000_FFFE);

    // Falling edge on pin 15, then set and clear in the same cycle.
    wr(A_FALL_EN, 32'h0000_8000);
    wr(A_IRQ_EN,  32'h0000_8001);
    wr(A_STATUS,  32'h0000_0001);
    check_val("w1c_bit0_irq", 32'(irq), 32'h0);
    @(negedge clk); level = 16'h7FFE;
    repeat (3) @(negedge clk);
    rd_chk("fall15_status", A_STATUS, 32'h0000_8000);
    check_val("fall15_irq", 32'(irq), 32'h1);
    level = 16'hFFFE;
    repeat (3) @(negedge clk);
    rd_chk("rise15_ignored", A_STATUS, 32'h0000_8000);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = A_STATUS; wdata = 32'h0000_8000; level = 16'h7FFE;
    @(negedge clk);
    req = 1'b0; we = 1'b0; wdata = '0;
    check_val("setclr_ack", 32'(ack), 32'h1);
    check_val("setclr_irq0", 32'(irq), 32'h1);
    @(negedge clk);
    check_val("setclr_irq1", 32'(irq), 32'h1);
    rd_chk("setclr_status", A_STATUS, 32'h0000_8000);
    wr(A_STATUS, 32'h0000_8000);
    check_val("clr15_irq", 32'(irq), 32'h0);
    rd_chk("clr15_status", A_STATUS, 32'h0);

    // W1C of the only pending bit drops irq one cycle after ack.
    @(negedge clk); level = 16'h7FFF;
    repeat (3) @(negedge clk);
    check_val("bit0_irq", 32'(irq), 32'h1);
    bus(1'b1, A_STATUS, 32'h0000_0001, rd, irq_ack);
    check_val("w1c_irq_at_ack", 32'(irq_ack), 32'h1);
    check_val("w1c_irq_after",  32'(irq),     32'h0);
    rd_chk("w1c_status", A_STATUS, 32'h0);
    rd_chk("level_rb2", A_LEVEL, 32'h0000_7FFF);

    // Enabling a pin that is already high does not create status.
    wr(A_RISE_EN, 32'h0000_0003);
    repeat (3) @(negedge clk);
    rd_chk("enable_no_retro", A_STATUS, 32'h0);
    rd_chk("rise_en_rb2", A_RISE_EN, 32'h3);
    rd_chk("fall_en_rb",  A_FALL_EN, 32'h0000_8000);
    rd_chk("irq_en_rb",   A_IRQ_EN,  32'h0000_8001);

    // Reserved addresses.
    wr(A_RSVD6, 32'hFFFF_FFFF);
    rd_chk("rsvd6", A_RSVD6, 32'h0);
    rd_chk("rsvd7", A_RSVD7, 32'h0);

`ifdef KRZ_GPIO_EVT_COUNT_EN
    wr(A_FALL_EN, 32'h0000_8001);
    wr(A_COUNT, 32'h0);
    rd_chk("count_clr0", A_COUNT, 32'h0);
    @(negedge clk); level = 16'h7FFE;
    repeat (2) @(negedge clk); level = 16'h7FFF;
    repeat (2) @(negedge clk); level = 16'h7FFE;
    repeat (2) @(negedge clk);
    rd_chk("count_3", A_COUNT, 32'h3);
    wr(A_COUNT, 32'h0);
    rd_chk("count_clr", A_COUNT, 32'h0);
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      level[0] = ~level[0];
    end
    repeat (2) @(negedge clk);
    rd_chk("count_sat", A_COUNT, 32'h0000_FFFF);
`else
    rd_chk("count_absent", A_COUNT, 32'h0);
`endif

    // Reset in the middle of an ACK cycle.
    @(negedge clk); level = 16'h7FFE;
    repeat (2) @(negedge clk); level = 16'h7FFF;
    repeat (3) @(negedge clk);
    check_val("pre_reset_irq", 32'(irq), 32'h1);
    req = 1'b1; we = 1'b0; addr = A_RISE_EN;
    @(posedge clk);
    #2;
    check_val("pre_reset_ack", 32'(ack), 32'h1);
    rst = 1'b1; req = 1'b0;
    #1;
    check_val("abort_ack",   32'(ack), 32'h0);
    check_val("abort_irq",   32'(irq), 32'h0);
    check_val("abort_rdata", rdata,    32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_no_ack", 32'(ack), 32'h0);
    rd_chk("post_reset_rise_en", A_RISE_EN, 32'h0);
    rd_chk("post_reset_status",  A_STATUS,  32'h0);
    rd_chk("post_reset_irq_en",  A_IRQ_EN,  32'h0);
    check_val("post_reset_irq", 32'(irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
